// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arb_pkg
//   Shared types and width helpers for the FIFO write-side arbiter.
//   - fifo_wr_arb_state_e : sequencer states (INIT, IDLE, BURST)
//   - clog2_min1()        : ceil(log2(n)) clamped to a minimum of 1 bit
//   - GNT_W / BEAT_W      : widths for the default configuration
//                           (NREQ=4, MAX_BURST=4)
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } fifo_wr_arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NREQ_DEFAULT      = 4;
  localparam int MAX_BURST_DEFAULT = 4;
  localparam int GNT_W  = clog2_min1(NREQ_DEFAULT);
  localparam int BEAT_W = clog2_min1(MAX_BURST_DEFAULT + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Selects the first asserted request
//   at or after ptr, wrapping modulo NREQ.
//   Ports:
//     req       in  NREQ   request vector
//     ptr       in  PTR_W  search start position (kept < NREQ by the caller)
//     gnt_id    out PTR_W  index of the winning request
//     gnt_valid out 1      any request asserted
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_id,
  output logic             gnt_valid
);

  function automatic int wrap_idx(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return (s >= NREQ) ? (s - NREQ) : s;
  endfunction

  // Scan from the farthest offset down to offset 0 so the closest
  // request to ptr is the last one written and therefore wins.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        gnt_id    = PTR_W'(wrap_idx(ptr, k));
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single asynchronous-FIFO write port among NREQ producers
//   using round-robin grants with bursts of at most MAX_BURST words, and
//   sequences the FIFO write-domain reset (wrst_n) after wrst.
//   Ports:
//     wclk       in   write clock
//     wrst       in   synchronous active-high reset
//     req_valid  in   NREQ        per-requester word valid
//     req_data   in   NREQ*DSIZE  requester i at [i*DSIZE +: DSIZE]
//     req_ready  out  NREQ        per-requester accept
//     wdata      out  DSIZE       FIFO write data
//     winc       out              FIFO write strobe
//     wrst_n     out              FIFO write reset, active-low, registered
//     wfull      in               FIFO full flag
//     grant_id   out  GNT bits    current/last granted requester
//     busy       out              high while in BURST
//     init_done  out              FIFO reset sequence complete
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DSIZE      = 8,
  parameter int MAX_BURST  = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DSIZE-1:0]        req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [DSIZE-1:0]             wdata,
  output logic                         winc,
  output logic                         wrst_n,
  input  logic                         wfull,
  output logic [clog2_min1(NREQ)-1:0]  grant_id,
  output logic                         busy,
  output logic                         init_done
);

  localparam int GW = clog2_min1(NREQ);
  localparam int BW = clog2_min1(MAX_BURST + 1);
  localparam int RW = clog2_min1(RST_CYCLES);

  fifo_wr_arb_state_e state_q, state_d;
  logic [RW-1:0]      rst_cnt_q, rst_cnt_d;
  logic               wrst_n_q, wrst_n_d;
  logic               init_done_q, init_done_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;

  logic [GW-1:0]      pick_id;
  logic               pick_valid;
  logic               sel_valid;
  logic [DSIZE-1:0]   sel_data;
  logic [GW-1:0]      next_ptr;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (GW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_id    (pick_id),
    .gnt_valid (pick_valid)
  );

  assign sel_valid = req_valid[grant_id_q];
  assign sel_data  = req_data[grant_id_q * DSIZE +: DSIZE];
  assign next_ptr  = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Transfer path: ready depends only on state and wfull, never on
  // req_valid, so producers may compute valid from ready without a loop.
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = sel_data;
    if (state_q == BURST) begin
      req_ready[grant_id_q] = ~wfull;
      winc                  = sel_valid & ~wfull;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    wrst_n_d    = wrst_n_q;
    init_done_d = init_done_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      INIT: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d     = IDLE;
          wrst_n_d    = 1'b1;
          init_done_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (winc) beat_cnt_d = beat_cnt_q + 1'b1;
        // A dropped valid releases the port even while stalled on wfull;
        // the final beat and the exit share one edge.
        if (!sel_valid || (winc && beat_cnt_q == BW'(MAX_BURST - 1))) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= INIT;
      rst_cnt_q   <= '0;
      wrst_n_q    <= 1'b0;
      init_done_q <= 1'b0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      wrst_n_q    <= wrst_n_d;
      init_done_q <= init_done_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign wrst_n    = wrst_n_q;
  assign init_done = init_done_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4,
// RST_CYCLES=4). Each requester i is a producer with a remaining-word
// count and a sequence number; its data word is i*16 + seq.
module tb_fifo_wr_arbiter;

  localparam int NREQ       = 4;
  localparam int DSIZE      = 8;
  localparam int MAX_BURST  = 4;
  localparam int RST_CYCLES = 4;

  logic                    wclk = 1'b0;
  logic                    wrst = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*DSIZE-1:0]   req_data = '0;
  logic [NREQ-1:0]         req_ready;
  logic [DSIZE-1:0]        wdata;
  logic                    winc;
  logic                    wrst_n;
  logic                    wfull = 1'b0;
  logic [1:0]              grant_id;
  logic                    busy;
  logic                    init_done;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NREQ       (NREQ),
    .DSIZE      (DSIZE),
    .MAX_BURST  (MAX_BURST),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wdata     (wdata),
    .winc      (winc),
    .wrst_n    (wrst_n),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy),
    .init_done (init_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rem [NREQ];
  int seq [NREQ];

  logic [7:0] log_data [64];
  int         log_gnt  [64];
  int         log_cyc  [64];
  int         log_n = 0;

  logic            s_winc;
  logic [NREQ-1:0] s_ready;
  logic [7:0]      s_wdata;
  logic [NREQ-1:0] fire;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (rem[i] != 0);
      req_data[i*DSIZE +: DSIZE] = 8'(i * 16 + seq[i]);
    end
  endtask

  // One clock: sample and log at the falling edge, update producers just
  // after the rising edge for every handshake that the edge completed.
  task automatic cycle();
    @(negedge wclk);
    s_winc  = winc;
    s_ready = req_ready;
    s_wdata = wdata;
    fire    = req_valid & req_ready;
    if (winc === 1'b1 && log_n < 64) begin
      log_data[log_n] = wdata;
      log_gnt[log_n]  = int'(grant_id);
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i] === 1'b1) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_rem();
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    drive();

    // ---------------- reset sequence ----------------
    run(2);
    wrst = 1'b0;
    check_val("rst_wrst_n", 32'(wrst_n), 32'd0);
    check_val("rst_init_done", 32'(init_done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_grant_id", 32'(grant_id), 32'd0);
    check_val("rst_winc", 32'(winc), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    for (int k = 1; k <= RST_CYCLES; k++) begin
      cycle();
      check_val($sformatf("init_winc_c%0d", k), 32'(s_winc), 32'd0);
      check_val($sformatf("init_wrst_n_c%0d", k), 32'(wrst_n), (k == RST_CYCLES) ? 32'd1 : 32'd0);
      check_val($sformatf("init_done_c%0d", k), 32'(init_done), (k == RST_CYCLES) ? 32'd1 : 32'd0);
    end

    // ---------------- round-robin fairness ----------------
    for (int i = 0; i < NREQ; i++) rem[i] = 8;
    drive();
    log_n = 0;
    run(25);
    clear_rem();
    cycle();
    check_val("rr_busy_end", 32'(busy), 32'd0);
    check_val("rr_count", 32'(log_n), 32'd20);
    for (int j = 0; j < 20; j++) begin
      int g;
      int s;
      g = (j / 4) % 4;
      s = (j < 16) ? (j % 4) : (4 + j % 4);
      check_val($sformatf("rr_gnt_%0d", j), 32'(log_gnt[j]), 32'(g));
      check_val($sformatf("rr_data_%0d", j), 32'(log_data[j]), 32'(g * 16 + s));
      if (j > 0)
        check_val($sformatf("rr_gap_%0d", j), 32'(log_cyc[j] - log_cyc[j-1]),
                  (j % 4 == 0) ? 32'd2 : 32'd1);
    end

    // ---------------- full stall at beat 2 ----------------
    log_n  = 0;
    rem[0] = 4;
    drive();
    cycle();
    check_val("stall_grant", 32'(grant_id), 32'd0);
    check_val("stall_busy", 32'(busy), 32'd1);
    run(2);
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val($sformatf("stall_winc_%0d", k), 32'(s_winc), 32'd0);
      check_val($sformatf("stall_ready_%0d", k), 32'(s_ready), 32'd0);
      check_val($sformatf("stall_wdata_%0d", k), 32'(s_wdata), 32'h0A);
      check_val($sformatf("stall_busy_%0d", k), 32'(busy), 32'd1);
    end
    wfull = 1'b0;
    run(2);
    check_val("stall_exit_busy", 32'(busy), 32'd0);
    run(2);
    check_val("stall_count", 32'(log_n), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check_val($sformatf("stall_data_%0d", j), 32'(log_data[j]), 32'(8 + j));
      check_val($sformatf("stall_gnt_%0d", j), 32'(log_gnt[j]), 32'd0);
    end

    // ---------------- early release ----------------
    log_n  = 0;
    rem[1] = 2;
    drive();
    cycle();
    check_val("early_grant", 32'(grant_id), 32'd1);
    run(2);
    rem[0] = 1;
    rem[2] = 1;
    rem[3] = 1;
    drive();
    cycle();
    check_val("early_exit_busy", 32'(busy), 32'd0);
    cycle();
    check_val("early_next_grant", 32'(grant_id), 32'd2);
    check_val("early_next_busy", 32'(busy), 32'd1);
    run(8);
    check_val("early_count", 32'(log_n), 32'd5);
    begin
      logic [7:0] exp_d [5];
      int         exp_g [5];
      exp_d[0] = 8'h14; exp_g[0] = 1;
      exp_d[1] = 8'h15; exp_g[1] = 1;
      exp_d[2] = 8'h24; exp_g[2] = 2;
      exp_d[3] = 8'h34; exp_g[3] = 3;
      exp_d[4] = 8'h0C; exp_g[4] = 0;
      for (int j = 0; j < 5; j++) begin
        check_val($sformatf("early_data_%0d", j), 32'(log_data[j]), 32'(exp_d[j]));
        check_val($sformatf("early_gnt_%0d", j), 32'(log_gnt[j]), 32'(exp_g[j]));
      end
    end
    check_val("early_idle_busy", 32'(busy), 32'd0);

    // ---------------- mid-burst reset ----------------
    rem[2] = 8;
    drive();
    cycle();
    check_val("mrst_grant", 32'(grant_id), 32'd2);
    cycle();
    wrst = 1'b1;
    cycle();
    check_val("mrst_winc", 32'(winc), 32'd0);
    check_val("mrst_wrst_n", 32'(wrst_n), 32'd0);
    check_val("mrst_init_done", 32'(init_done), 32'd0);
    check_val("mrst_grant_id", 32'(grant_id), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_ready", 32'(req_ready), 32'd0);
    wrst = 1'b0;
    for (int k = 1; k <= RST_CYCLES; k++) begin
      cycle();
      check_val($sformatf("mrst_init_ready_c%0d", k), 32'(s_ready), 32'd0);
      check_val($sformatf("mrst_init_winc_c%0d", k), 32'(s_winc), 32'd0);
    end
    check_val("mrst_wrst_n_rel", 32'(wrst_n), 32'd1);
    clear_rem();

    // ---------------- single requester ----------------
    log_n  = 0;
    rem[3] = 10;
    drive();
    run(16);
    check_val("single_count", 32'(log_n), 32'd10);
    check_val("single_busy_end", 32'(busy), 32'd0);
    for (int j = 0; j < 10; j++) begin
      check_val($sformatf("single_gnt_%0d", j), 32'(log_gnt[j]), 32'd3);
      check_val($sformatf("single_data_%0d", j), 32'(log_data[j]), 32'(8'h35 + j));
      if (j > 0)
        check_val($sformatf("single_gap_%0d", j), 32'(log_cyc[j] - log_cyc[j-1]),
                  (j == 4 || j == 8) ? 32'd2 : 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter and sequencer for the asynchronous FIFO write port. It shares the single FIFO write port (`wdata`/`winc`/`wfull`) among `NREQ` requesters using round-robin arbitration with bounded bursts, and it owns the FIFO write-domain reset sequencing by driving `wrst_n`. It sits entirely in the write clock domain, between producer blocks and the FIFO write interface.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DSIZE`, default 8: data width; must equal the FIFO `DSIZE`.
- `MAX_BURST`, default 4: maximum words accepted per grant, ≥1.
- `RST_CYCLES`, default 4: cycles `wrst_n` is held low after reset, ≥1.

Ports:
- `wclk`  in  1  write clock; all logic on posedge.
- `wrst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester word valid.
- `req_data`  in  NREQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE].
- `req_ready`  out  NREQ  per-requester accept; a transfer occurs when valid and ready are both high.
- `wdata`  out  DSIZE  FIFO write data.
- `winc`  out  1  FIFO write strobe.
- `wrst_n`  out  1  FIFO write-domain reset, active-low, registered.
- `wfull`  in  1  FIFO full flag.
- `grant_id`  out  $clog2(NREQ)  current/last granted requester.
- `busy`  out  1  high in BURST.
- `init_done`  out  1  high once the FIFO reset sequence has completed.

## Operation
- FSM states: INIT, IDLE, BURST.
- **INIT.** `wrst_n`=0. A counter runs 0..RST_CYCLES-1. On the terminal count, the FSM goes to IDLE and `wrst_n` and `init_done` go to 1 on the same edge.
- **IDLE.** If any `req_valid` is high, the round-robin picker selects the first valid requester at or after `rr_ptr`, wrapping modulo NREQ. On that edge: `grant_id` <= winner, `beat_cnt` <= 0, state <= BURST. No transfer occurs in IDLE.
- **BURST** (transfer logic, combinational):
  - `req_ready[grant_id] = ~wfull`; all other `req_ready` bits are 0.
  - `winc = req_valid[grant_id] & ~wfull`.
  - `wdata = req_data[grant_id]`, driven regardless of `winc`.
- **BURST** (state updates):
  - Each transfer increments `beat_cnt`.
  - Exit to IDLE when a transfer makes `beat_cnt` reach MAX_BURST, or when `req_valid[grant_id]`=0, whatever `wfull` is.
  - On every exit, `rr_ptr` <= `grant_id`+1, wrapping at NREQ.
  - `wfull`=1 with valid high: stall. Stay in BURST, `beat_cnt` holds, no beat is lost or duplicated.
- **Width.** `beat_cnt` is $clog2(MAX_BURST+1) bits; `rr_ptr` and `grant_id` are $clog2(NREQ) bits, minimum 1.
- **Outputs in INIT and IDLE.** `winc`=0 and `req_ready`=0.
- **No overflow.** Overflow is impossible by construction because `winc` is gated by the current `wfull`.

## Timing
- **Reset values** (`wrst` high at a posedge; takes effect that edge, from any state including mid-burst):
  - state INIT, counter 0, `wrst_n`=0, `init_done`=0.
  - `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0.
  - `busy`=0, `winc`=0, `req_ready`=0.
- **Reset release.** After `wrst` deasserts, `wrst_n` rises exactly RST_CYCLES posedges later.
- **Grant latency.** One cycle from IDLE to the first possible beat.
- **Throughput.** Back-to-back bursts have a one-cycle IDLE bubble; sustained throughput is MAX_BURST/(MAX_BURST+1).
- **Combinational paths.** `winc`, `req_ready` and `wdata` are combinational from registered state plus `req_valid`, `req_data` and `wfull`. There is no combinational path from `req_valid` to `req_ready`.
- **Simultaneous events.** On the last beat of a burst, the transfer completes and the exit happens on the same edge. A new request arriving that edge is considered in the next IDLE cycle.

## Structure
- **Package `fifo_wr_arb_pkg`.** Holds the `fifo_wr_arb_state_e` enum (INIT, IDLE, BURST) and width helper localparams (`GNT_W`, `BEAT_W`).
- **Sub-module `rr_arbiter`.** Combinational picker with inputs `req[NREQ]` and `ptr`, and outputs `gnt_id` and `gnt_valid`. The FSM, counters and muxing live in `fifo_wr_arbiter`.

## Test plan
- **Reset sequence.** RST_CYCLES=4; deassert `wrst` at cycle 0. Required: `wrst_n`=0 through cycle 3, `wrst_n`=1 and `init_done`=1 at cycle 4, `winc`=0 throughout.
- **Round-robin fairness.** All 4 requesters continuously valid, MAX_BURST=4. Required: bursts of 4 words granted 0,1,2,3,0 with one bubble cycle between bursts; FIFO contents are in grant order.
- **Full stall.** Hold `wfull`=1 for 3 cycles in mid-burst at beat 2. Required: `winc`=0 and `req_ready`=0 during the stall; the burst resumes at beat 2 and delivers exactly 4 words total.
- **Early release.** Requester 1 drops valid after 2 beats. Required: exit to IDLE, `rr_ptr`=2, and the next grant goes to requester 2 if it is valid.
- **Mid-burst reset.** Assert `wrst` at beat 1. Required: next cycle `winc`=0, `wrst_n`=0, state INIT, `grant_id`=0.
- **Single requester.** Only requester 3 is valid with 10 words. Required: bursts of 4, 4 and 2 words, all with `grant_id`=3.
